// File: rtl/cordic_phase_gen.sv
// NCO front-end for the CORDIC rotator: phase accumulator with rate divider, burst control and
// sample-aligned frequency update. Optional linear chirp of the frequency word via `CHIRP_EN.
module cordic_phase_gen #(
    parameter int unsigned XY_BITS  = 12,
    parameter int unsigned PH_BITS  = 32,
    parameter int unsigned DIV_BITS = 16,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clk_in,
    input  logic                RST,
    input  logic                start,
    input  logic                stop,
    input  logic [PH_BITS-1:0]  fcw_in,
    input  logic                fcw_load,
    input  logic [PH_BITS-1:0]  pho_in,
    input  logic [XY_BITS-1:0]  amp_in,
    input  logic [DIV_BITS-1:0] div_in,
    input  logic [CNT_BITS-1:0] burst_len,
    input  logic [PH_BITS-1:0]  chirp_step,
    output logic [XY_BITS-1:0]  x_o,
    output logic [XY_BITS-1:0]  y_o,
    output logic [PH_BITS-1:0]  phase_out,
    output logic                valid_out,
    output logic                busy,
    output logic                done
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [PH_BITS-1:0]  acc_q, acc_d;
    logic [PH_BITS-1:0]  pho_q, pho_d;
    logic [PH_BITS-1:0]  shadow_q, shadow_d;
    logic [PH_BITS-1:0]  fcw_act_q, fcw_act_d;
    logic [PH_BITS-1:0]  phase_q, phase_d;
    logic                pend_q, pend_d;
    logic [DIV_BITS-1:0] div_q, div_d;
    logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_BITS-1:0] burst_q, burst_d;
    logic [CNT_BITS-1:0] smp_cnt_q, smp_cnt_d;
    logic [XY_BITS-1:0]  x_q, x_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    logic                tick;
    logic                entering;
    logic [PH_BITS-1:0]  inc;
    logic [PH_BITS-1:0]  acc_base;
    logic [PH_BITS-1:0]  offs;
    logic [CNT_BITS-1:0] cnt_next;
    logic [CNT_BITS-1:0] blen;

`ifndef CHIRP_EN
    logic unused_chirp;
    assign unused_chirp = ^chirp_step;
`endif

    // Increment for the next sample: a load in this very cycle, else the pending shadow, else the active word.
    assign inc = fcw_load ? fcw_in : (pend_q ? shadow_q : fcw_act_q);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        pho_d     = pho_q;
        shadow_d  = fcw_load ? fcw_in : shadow_q;
        pend_d    = pend_q | fcw_load;
        fcw_act_d = fcw_act_q;
        phase_d   = phase_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        burst_d   = burst_q;
        smp_cnt_d = smp_cnt_q;
        x_d       = x_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        tick      = 1'b0;
        entering  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    entering  = 1'b1;
                    tick      = 1'b1;
                    state_d   = S_RUN;
                    pho_d     = pho_in;
                    div_d     = div_in;
                    burst_d   = burst_len;
                    x_d       = amp_in;
                    div_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (div_cnt_q == div_q) begin
                    tick      = 1'b1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_BITS'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The entry sample uses the freshly latched settings with a cleared accumulator and count.
        acc_base = entering ? '0 : acc_q;
        offs     = entering ? pho_in : pho_q;
        cnt_next = entering ? CNT_BITS'(1) : smp_cnt_q + CNT_BITS'(1);
        blen     = entering ? burst_len : burst_q;

        if (tick) begin
            phase_d   = acc_base + offs;
            valid_d   = 1'b1;
            acc_d     = acc_base + inc;
            smp_cnt_d = cnt_next;
            pend_d    = 1'b0;
`ifdef CHIRP_EN
            fcw_act_d = fcw_load ? fcw_in : inc + chirp_step;
`else
            fcw_act_d = inc;
`endif
            if ((blen != '0) && (cnt_next == blen)) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            pho_q     <= '0;
            shadow_q  <= '0;
            fcw_act_q <= '0;
            phase_q   <= '0;
            pend_q    <= 1'b0;
            div_q     <= '0;
            div_cnt_q <= '0;
            burst_q   <= '0;
            smp_cnt_q <= '0;
            x_q       <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            pho_q     <= pho_d;
            shadow_q  <= shadow_d;
            fcw_act_q <= fcw_act_d;
            phase_q   <= phase_d;
            pend_q    <= pend_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            burst_q   <= burst_d;
            smp_cnt_q <= smp_cnt_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = '0;
    assign phase_out = phase_q;
    assign valid_out = valid_q;
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Bench for cordic_phase_gen: sample-level reference model checked every cycle, plus literal
// phase sequences per scenario. Build with CHIRP_EN defined to cover the chirp variant.
module tb_cordic_phase_gen;

    logic        clk_in;
    logic        RST;
    logic        start;
    logic        stop;
    logic [31:0] fcw_in;
    logic        fcw_load;
    logic [31:0] pho_in;
    logic [11:0] amp_in;
    logic [15:0] div_in;
    logic [15:0] burst_len;
    logic [31:0] chirp_step;
    logic [11:0] x_o;
    logic [11:0] y_o;
    logic [31:0] phase_out;
    logic        valid_out;
    logic        busy;
    logic        done;

    cordic_phase_gen #(
        .XY_BITS (12),
        .PH_BITS (32),
        .DIV_BITS(16),
        .CNT_BITS(16)
    ) dut (
        .clk_in    (clk_in),
        .RST       (RST),
        .start     (start),
        .stop      (stop),
        .fcw_in    (fcw_in),
        .fcw_load  (fcw_load),
        .pho_in    (pho_in),
        .amp_in    (amp_in),
        .div_in    (div_in),
        .burst_len (burst_len),
        .chirp_step(chirp_step),
        .x_o       (x_o),
        .y_o       (y_o),
        .phase_out (phase_out),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int cyc = 0;
    logic [31:0] plog[$];
    int          vlog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: works in absolute sample times and "increment for the next sample".
    localparam longint MASK = 64'hFFFF_FFFF;
    bit          m_run = 0;
    longint      m_cyc = 0;
    longint      m_next = 0;
    longint      m_acc = 0;
    longint      m_off = 0;
    longint      m_ninc = 0;
    int          m_cnt = 0;
    int          m_burst = 0;
    int          m_per = 1;
    logic [11:0] m_amp = '0;
    bit          e_valid = 0;
    bit          e_done = 0;
    logic [31:0] e_phase = '0;

    task automatic model_edge();
        bit tk;
        e_valid = 0;
        e_done  = 0;
        if (!RST) begin
            m_run  = 0;
            m_acc  = 0;
            m_ninc = 0;
            m_cnt  = 0;
            m_amp  = '0;
            e_phase = '0;
            m_cyc++;
            return;
        end
        tk = 0;
        if (!m_run) begin
            if (start) begin
                m_run   = 1;
                tk      = 1;
                m_acc   = 0;
                m_cnt   = 0;
                m_off   = longint'(pho_in);
                m_per   = int'(div_in) + 1;
                m_burst = int'(burst_len);
                m_amp   = amp_in;
            end
        end else if (stop) begin
            m_run = 0;
        end else if (m_cyc == m_next) begin
            tk = 1;
        end
        if (fcw_load) m_ninc = longint'(fcw_in);
        if (tk) begin
            e_phase = 32'((m_acc + m_off) & MASK);
            e_valid = 1;
            m_acc   = (m_acc + m_ninc) & MASK;
            m_cnt++;
            m_next  = m_cyc + m_per;
`ifdef CHIRP_EN
            if (!fcw_load) m_ninc = (m_ninc + longint'(chirp_step)) & MASK;
`endif
            if (m_burst != 0 && m_cnt == m_burst) begin
                m_run  = 0;
                e_done = 1;
            end
        end
        m_cyc++;
    endtask

    always @(posedge clk_in) begin
        model_edge();
        #1;
        chk("valid_out", valid_out, e_valid);
        chk("done", done, e_done);
        chk("busy", busy, m_run);
        chk("phase_out", phase_out, e_phase);
        chk("x_o", x_o, m_amp);
        chk("y_o", y_o, 12'h000);
        if (valid_out) begin
            plog.push_back(phase_out);
            vlog.push_back(cyc);
        end
        if (done) n_done++;
        cyc++;
    end

    task automatic load_fcw(input logic [31:0] v);
        fcw_in   = v;
        fcw_load = 1'b1;
        @(negedge clk_in);
        fcw_load = 1'b0;
    endtask

    task automatic pulse_start();
        plog.delete();
        vlog.delete();
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk_in);
        stop = 1'b0;
    endtask

    task automatic chk_log(input string name, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3, input int n);
        logic [31:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({name, "_count"}, 64'(plog.size()), 64'(n));
        for (int i = 0; i < n && i < plog.size(); i++)
            chk($sformatf("%s_%0d", name, i), plog[i], e[i]);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin : stim
        int d0;
        RST = 1'b0; start = 1'b0; stop = 1'b0; fcw_in = '0; fcw_load = 1'b0;
        pho_in = '0; amp_in = '0; div_in = '0; burst_len = '0; chirp_step = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_phase", phase_out, 32'h0);
        chk("rst_busy", busy, 1'b0);
        RST = 1'b1;
        @(negedge clk_in);

        // Quarter-turn burst of 4
        load_fcw(32'h4000_0000);
        div_in = 16'd0; pho_in = 32'h0; burst_len = 16'd4; amp_in = 12'h5A5;
        d0 = n_done;
        pulse_start();
        repeat (6) @(negedge clk_in);
        chk_log("quarter", 32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 4);
        chk("quarter_done", 64'(n_done - d0), 64'd1);
        chk("quarter_busy_end", busy, 1'b0);
        chk("quarter_x", x_o, 12'h5A5);

        // Wrap with negative effective step
        load_fcw(32'hFFFF_FFFF);
        div_in = 16'd1; pho_in = 32'h10; burst_len = 16'd3; amp_in = 12'hFFB;
        pulse_start();
        repeat (8) @(negedge clk_in);
        chk_log("wrap", 32'h10, 32'h0F, 32'h0E, 32'h0, 3);
        chk("wrap_x", x_o, 12'hFFB);
        chk("wrap_y", y_o, 12'h000);

        // Continuous, period 4, then stop on a tick
        load_fcw(32'h1);
        div_in = 16'd3; pho_in = 32'h0; burst_len = 16'd0;
        d0 = n_done;
        pulse_start();
        repeat (17) @(negedge clk_in);
        chk("div3_count", 64'(vlog.size()), 64'd5);
        for (int i = 1; i < vlog.size(); i++)
            chk($sformatf("div3_spacing_%0d", i), 64'(vlog[i] - vlog[i-1]), 64'd4);
        repeat (2) @(negedge clk_in);
        pulse_stop();
        chk("stop_no_strobe", valid_out, 1'b0);
        chk("stop_idle", busy, 1'b0);
        chk("stop_no_done", 64'(n_done - d0), 64'd0);
        chk("stop_count", 64'(vlog.size()), 64'd5);

        // Frequency switch between ticks; start while running is ignored
        load_fcw(32'h100);
        div_in = 16'd2; burst_len = 16'd0; pho_in = 32'h0;
        pulse_start();
        fcw_in = 32'h1000; fcw_load = 1'b1; start = 1'b1;
        @(negedge clk_in);
        fcw_load = 1'b0; start = 1'b0;
        repeat (8) @(negedge clk_in);
        chk_log("fcw_switch", 32'h0, 32'h100, 32'h1100, 32'h2100, 4);
        pulse_stop();
        @(negedge clk_in);

        // start and stop together in IDLE: start wins, single-sample burst
        pho_in = 32'h55; burst_len = 16'd1; div_in = 16'd0;
        d0 = n_done;
        plog.delete();
        start = 1'b1; stop = 1'b1;
        @(negedge clk_in);
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk_in);
        chk_log("start_stop", 32'h55, 32'h0, 32'h0, 32'h0, 1);
        chk("start_stop_done", 64'(n_done - d0), 64'd1);

        // Chirp (step ignored unless CHIRP_EN)
        load_fcw(32'h100);
        chirp_step = 32'h10; div_in = 16'd0; pho_in = 32'h0; burst_len = 16'd4;
        pulse_start();
        repeat (6) @(negedge clk_in);
`ifdef CHIRP_EN
        chk_log("chirp", 32'h0, 32'h100, 32'h210, 32'h330, 4);
`else
        chk_log("chirp", 32'h0, 32'h100, 32'h200, 32'h300, 4);
`endif
        chirp_step = '0;

        // Asynchronous reset mid-run
        load_fcw(32'h333);
        burst_len = 16'd0; amp_in = 12'h123;
        pulse_start();
        repeat (3) @(negedge clk_in);
        d0 = n_done;
        #2 RST = 1'b0;
        #1;
        chk("arst_valid", valid_out, 1'b0);
        chk("arst_phase", phase_out, 32'h0);
        chk("arst_x", x_o, 12'h000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        RST = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("arst_idle_after", busy, 1'b0);
        chk("arst_no_done", 64'(n_done - d0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
